ls_endian_sequencer: RTL
========================

Name: ls_endian_sequencer

Overview:
Single-outstanding load/store sequencer between the core load/store unit and the little-endian data bus. Latches one core request, byte-swaps mask and store data when big-endian mode is active, drives the bus handshake, and waits for load data. Returns the load data to the core byte-swapped back and masked, with a timeout error if the bus never answers.

Parameters:
P_TO_W, 8, width of the load-wait timeout counter; timeout fires after 2^P_TO_W-1 WAIT cycles with no iBUS_VALID.

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iRESET_SYNC  in  1  synchronous clear, same effect as reset
iBIG_ENDIAN  in  1  endian mode, 1=big; sampled only at request accept
iCORE_REQ  in  1  core request strobe
oCORE_BUSY  out  1  sequencer not in IDLE; core holds off new requests
iCORE_RW  in  1  1=store, 0=load
iCORE_ADDR  in  32  word address
iCORE_MASK  in  4  byte enables, core byte order
iCORE_DATA  in  32  store data, core byte order
oCORE_VALID  out  1  one-cycle completion pulse
oCORE_ERROR  out  1  completion is a timeout; qualified by oCORE_VALID
oCORE_DATA  out  32  load data, core byte order; 0 for stores and errors
oBUS_REQ  out  1  bus request, held until accepted
iBUS_BUSY  in  1  bus stall; request accepted in a cycle with oBUS_REQ=1 and iBUS_BUSY=0
oBUS_RW  out  1  latched RW
oBUS_ADDR  out  32  latched address
oBUS_MASK  out  4  mask, bus byte order
oBUS_DATA  out  32  store data, bus byte order
iBUS_VALID  in  1  load data valid
iBUS_DATA  in  32  load data, bus byte order

Behaviour:
- Reset (inRESET low or iRESET_SYNC high): state IDLE; every output 0; counter 0; latched mode 0.
- Swap: byte b moves to byte 3-b for data, and mask bit b moves to bit 3-b. Applied only when the latched mode = 1.
- FSM states: IDLE, ISSUE, WAIT, RESP. oCORE_BUSY=1 in every state except IDLE.
- IDLE:
  - On iCORE_REQ: latch RW, ADDR, mode, and the swapped-if-big mask and data.
  - Mask != 0 -> ISSUE.
  - Mask == 0 -> RESP directly. No bus request, VALID=1, ERROR=0, DATA=0.
- ISSUE: oBUS_REQ=1; oBUS_* driven from the latches and held stable while iBUS_BUSY=1. On accept (iBUS_BUSY=0):
  - store -> RESP
  - load -> WAIT, counter cleared
- WAIT: oBUS_REQ=0; counter increments each cycle.
  - iBUS_VALID=1 -> capture iBUS_DATA, swap if latched big, zero the bytes whose core-order mask bit is 0, ERROR=0 -> RESP.
  - Else, counter == 2^P_TO_W-1 -> ERROR=1, DATA=0 -> RESP.
  - iBUS_VALID in the timeout cycle: valid wins, no error.
- RESP: oCORE_VALID=1 for exactly one cycle with DATA/ERROR -> IDLE. DATA/ERROR return to 0 the next cycle.
- Latency from the accept edge T0:
  - store, bus not busy: oBUS_REQ at T1, oCORE_VALID at T2
  - load with iBUS_VALID at T2: oCORE_VALID at T3
  - iBUS_BUSY for n cycles adds n
- iCORE_REQ outside IDLE: ignored. iBIG_ENDIAN changes mid-transaction: no effect. iBUS_VALID outside WAIT: ignored; this includes a late response after a timeout or a sync reset.
- Reset mid-transaction: immediate return to IDLE, oBUS_REQ dropped. The bus must tolerate request withdrawal on reset.
- Core mask/data are registered at accept; the core need not hold them after the accept cycle.

Decomposition:
- Shared package: state encodings (L_PARAM_IDLE/ISSUE/WAIT/RESP, 2 bits) and RW encoding constants (store=1, load=0).
- One sub-module: instantiate the existing combinational byte-swap module endian_controller twice, on the request path and the load-return path. Mode muxing stays in this block.

Test Plan:
- Little-endian store: mode=0, RW=1, ADDR=0x100, MASK=4'b0011, DATA=0x11223344, bus not busy -> oBUS_MASK=0011, oBUS_DATA=0x11223344 at T1; oCORE_VALID=1, ERROR=0 at T2.
- Big-endian store with 3-cycle iBUS_BUSY: MASK=0001, DATA=0xAABBCCDD -> oBUS_MASK=1000, oBUS_DATA=0xDDCCBBAA, both held stable for 4 cycles; VALID one cycle after accept.
- Big-endian load: MASK=1111, iBUS_DATA=0x01020304 at T2 -> oCORE_DATA=0x04030201, VALID at T3. Repeat with MASK=0011 -> oCORE_DATA=0x00000201.
- Timeout: load, P_TO_W=3, iBUS_VALID never asserted -> VALID=1, ERROR=1, DATA=0 after 7 WAIT cycles. A later iBUS_VALID is ignored and the next request completes normally.
- Boundary: MASK=0 request -> VALID next cycle, oBUS_REQ never asserted. iBUS_VALID coincident with the timeout cycle -> ERROR=0, data returned.
- Reset mid-ISSUE with iBUS_BUSY=1: pulse inRESET low (async), then repeat with iRESET_SYNC -> all outputs 0, BUSY=0 immediately, and a new request is accepted afterwards.

Source files
------------

// File: rtl/ls_endian_sequencer_pkg.sv
// Shared encodings for the load/store endian sequencer: FSM states, RW codes
// and the byte-enable expansion used on the load-return path.
package ls_endian_sequencer_pkg;

  typedef enum logic [1:0] {
    L_PARAM_IDLE  = 2'd0,
    L_PARAM_ISSUE = 2'd1,
    L_PARAM_WAIT  = 2'd2,
    L_PARAM_RESP  = 2'd3
  } state_t;

  localparam logic L_PARAM_STORE = 1'b1;
  localparam logic L_PARAM_LOAD  = 1'b0;

  // Widens a 4-bit byte-enable into a 32-bit AND mask (bit b covers byte b).
  function automatic logic [31:0] byte_enable_mask(input logic [3:0] mask);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{mask[b]}};
    return m;
  endfunction

endpackage

// File: rtl/ls_endian_sequencer_if.sv
// Core-side and bus-side handshake of the sequencer. master = sequencer view,
// slave = the surrounding core/bus environment.
interface ls_endian_sequencer_if;

  logic        iCORE_REQ;
  logic        oCORE_BUSY;
  logic        iCORE_RW;
  logic [31:0] iCORE_ADDR;
  logic [3:0]  iCORE_MASK;
  logic [31:0] iCORE_DATA;
  logic        oCORE_VALID;
  logic        oCORE_ERROR;
  logic [31:0] oCORE_DATA;

  logic        oBUS_REQ;
  logic        iBUS_BUSY;
  logic        oBUS_RW;
  logic [31:0] oBUS_ADDR;
  logic [3:0]  oBUS_MASK;
  logic [31:0] oBUS_DATA;
  logic        iBUS_VALID;
  logic [31:0] iBUS_DATA;

  modport master (
    input  iCORE_REQ, iCORE_RW, iCORE_ADDR, iCORE_MASK, iCORE_DATA,
    input  iBUS_BUSY, iBUS_VALID, iBUS_DATA,
    output oCORE_BUSY, oCORE_VALID, oCORE_ERROR, oCORE_DATA,
    output oBUS_REQ, oBUS_RW, oBUS_ADDR, oBUS_MASK, oBUS_DATA
  );

  modport slave (
    output iCORE_REQ, iCORE_RW, iCORE_ADDR, iCORE_MASK, iCORE_DATA,
    output iBUS_BUSY, iBUS_VALID, iBUS_DATA,
    input  oCORE_BUSY, oCORE_VALID, oCORE_ERROR, oCORE_DATA,
    input  oBUS_REQ, oBUS_RW, oBUS_ADDR, oBUS_MASK, oBUS_DATA
  );

endinterface

// File: rtl/ls_endian_sequencer_endian_controller.sv
// Unconditional byte swap: byte b <-> byte 3-b, mask bit b <-> bit 3-b.
// Callers decide whether to use the swapped or the straight value.
module endian_controller (
  input  logic [31:0] data,
  input  logic [3:0]  mask,
  output logic [31:0] swapped_data,
  output logic [3:0]  swapped_mask
);

  assign swapped_data = {data[7:0], data[15:8], data[23:16], data[31:24]};
  assign swapped_mask = {mask[0], mask[1], mask[2], mask[3]};

endmodule

// File: rtl/ls_endian_sequencer.sv
// Single-outstanding load/store sequencer between the core LSU and a
// little-endian bus, with big-endian swapping and a load-wait timeout.
module ls_endian_sequencer
  import ls_endian_sequencer_pkg::*;
#(
  parameter int P_TO_W = 8
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iRESET_SYNC,
  input  logic                  iBIG_ENDIAN,
  ls_endian_sequencer_if.master port
);

  localparam logic [P_TO_W-1:0] L_CNT_ONE = P_TO_W'(1);
  localparam logic [P_TO_W-1:0] L_CNT_MAX = '1;

  state_t            state, state_nxt;
  logic              lat_rw, lat_big;
  logic [31:0]       lat_addr, lat_data;
  logic [3:0]        lat_mask;
  logic [P_TO_W-1:0] to_cnt, to_cnt_inc;
  logic              timeout;
  logic [31:0]       resp_data;
  logic              resp_error;

  logic [31:0] req_sw_data, req_data, ret_sw_data, ret_data;
  logic [3:0]  req_sw_mask, req_mask, ret_sw_mask, core_mask;
  logic        in_issue, in_resp;

  endian_controller u_req_swap (
    .data         (port.iCORE_DATA),
    .mask         (port.iCORE_MASK),
    .swapped_data (req_sw_data),
    .swapped_mask (req_sw_mask)
  );

  // The latched mask is in bus order; swapping it back yields the core-order
  // byte enables needed to clear unrequested bytes of the load result.
  endian_controller u_ret_swap (
    .data         (port.iBUS_DATA),
    .mask         (lat_mask),
    .swapped_data (ret_sw_data),
    .swapped_mask (ret_sw_mask)
  );

  assign req_data   = iBIG_ENDIAN ? req_sw_data : port.iCORE_DATA;
  assign req_mask   = iBIG_ENDIAN ? req_sw_mask : port.iCORE_MASK;
  assign core_mask  = lat_big ? ret_sw_mask : lat_mask;
  assign ret_data   = (lat_big ? ret_sw_data : port.iBUS_DATA) & byte_enable_mask(core_mask);
  assign to_cnt_inc = to_cnt + L_CNT_ONE;
  assign timeout    = (to_cnt_inc == L_CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= L_PARAM_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      L_PARAM_IDLE:  if (port.iCORE_REQ) state_nxt = (req_mask != 4'b0) ? L_PARAM_ISSUE : L_PARAM_RESP;
      L_PARAM_ISSUE: if (!port.iBUS_BUSY) state_nxt = (lat_rw == L_PARAM_STORE) ? L_PARAM_RESP : L_PARAM_WAIT;
      L_PARAM_WAIT:  if (port.iBUS_VALID || timeout) state_nxt = L_PARAM_RESP;
      L_PARAM_RESP:  state_nxt = L_PARAM_IDLE;
      default:       state_nxt = L_PARAM_IDLE;
    endcase
    if (iRESET_SYNC) state_nxt = L_PARAM_IDLE;

    // Outputs are masked by the synchronous clear so a withdrawn request and
    // a quiet core port are seen as soon as the clear is asserted.
    in_issue = (state == L_PARAM_ISSUE) && !iRESET_SYNC;
    in_resp  = (state == L_PARAM_RESP) && !iRESET_SYNC;

    port.oCORE_BUSY  = (state != L_PARAM_IDLE) && !iRESET_SYNC;
    port.oCORE_VALID = in_resp;
    port.oCORE_ERROR = in_resp && resp_error;
    port.oCORE_DATA  = in_resp ? resp_data : '0;
    port.oBUS_REQ    = in_issue;
    port.oBUS_RW     = in_issue && lat_rw;
    port.oBUS_ADDR   = in_issue ? lat_addr : '0;
    port.oBUS_MASK   = in_issue ? lat_mask : '0;
    port.oBUS_DATA   = in_issue ? lat_data : '0;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      lat_rw     <= L_PARAM_LOAD;
      lat_big    <= 1'b0;
      lat_addr   <= '0;
      lat_mask   <= '0;
      lat_data   <= '0;
      to_cnt     <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else if (iRESET_SYNC) begin
      lat_rw     <= L_PARAM_LOAD;
      lat_big    <= 1'b0;
      lat_addr   <= '0;
      lat_mask   <= '0;
      lat_data   <= '0;
      to_cnt     <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      unique case (state)
        L_PARAM_IDLE: if (port.iCORE_REQ) begin
          lat_rw     <= port.iCORE_RW;
          lat_addr   <= port.iCORE_ADDR;
          lat_big    <= iBIG_ENDIAN;
          lat_mask   <= req_mask;
          lat_data   <= req_data;
          resp_data  <= '0;
          resp_error <= 1'b0;
        end
        L_PARAM_ISSUE: if (!port.iBUS_BUSY) to_cnt <= '0;
        L_PARAM_WAIT: begin
          to_cnt <= to_cnt_inc;
          if (port.iBUS_VALID) begin
            resp_data  <= ret_data;
            resp_error <= 1'b0;
          end else if (timeout) begin
            resp_data  <= '0;
            resp_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
